// File: rtl/booth_seq_multiplier_pkg.sv
// mult_pkg: shared types and helpers for the sequential radix-4 Booth multiplier
package mult_pkg;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  typedef struct packed {
    logic neg;
    logic one;
    logic two;
  } booth_digit_t;
  function automatic int iter_count(input int width);
    return width / 2 + 1;
  endfunction
endpackage

// File: rtl/booth_r4_encoder.sv
// booth_r4_encoder: maps a multiplier bit triple to radix-4 Booth digit flags
module booth_r4_encoder
  import mult_pkg::*;
(
  input  logic [2:0]   triple,
  output booth_digit_t digit
);
  always_comb begin
    digit.neg = triple[2] & ~(triple[1] & triple[0]);
    digit.one = triple[1] ^ triple[0];
    digit.two = (triple == 3'b011) | (triple == 3'b100);
  end
endmodule

// File: rtl/booth_seq_multiplier.sv
// booth_seq_multiplier: sequential radix-4 Booth multiplier, one digit per cycle,
// valid/ready on both sides, per-transaction signed/unsigned mode
module booth_seq_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic               is_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] S
);
  localparam int W2 = WIDTH + 2;
  localparam int ITER = iter_count(WIDTH);
  localparam int CW = $clog2(ITER);
  state_t state_q, state_d;
  logic [W2:0] hi_q, hi_d, pp, sum;
  logic [W2-1:0] lo_q, lo_d, a_q, a_d;
  logic prev_q, prev_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2*WIDTH-1:0] s_q, s_d;
  booth_digit_t dig;
  booth_r4_encoder u_enc (
    .triple({lo_q[1:0], prev_q}),
    .digit (dig)
  );
  // hi holds the running partial product; lo shifts out multiplier bits and shifts in product bits
  always_comb begin
    pp = dig.two ? {a_q, 1'b0} : dig.one ? {a_q[W2-1], a_q} : '0;
    sum = hi_q + (dig.neg ? -pp : pp);
    state_d = state_q;
    hi_d = hi_q;
    lo_d = lo_q;
    prev_d = prev_q;
    a_d = a_q;
    cnt_d = cnt_q;
    s_d = s_q;
    unique case (state_q)
      IDLE: if (in_valid) begin
        state_d = CALC;
        a_d = is_signed ? {{2{A[WIDTH-1]}}, A} : {2'b00, A};
        lo_d = is_signed ? {{2{B[WIDTH-1]}}, B} : {2'b00, B};
        hi_d = '0;
        prev_d = 1'b0;
        cnt_d = '0;
      end
      CALC: begin
        hi_d = {{2{sum[W2]}}, sum[W2:2]};
        lo_d = {sum[1:0], lo_q[W2-1:2]};
        prev_d = lo_q[1];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(ITER - 1)) begin
          state_d = DONE;
          s_d = {sum[WIDTH-1:0], lo_q[W2-1:2]};
        end
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      hi_q <= '0;
      lo_q <= '0;
      prev_q <= 1'b0;
      a_q <= '0;
      cnt_q <= '0;
      s_q <= '0;
    end else begin
      state_q <= state_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      prev_q <= prev_d;
      a_q <= a_d;
      cnt_q <= cnt_d;
      s_q <= s_d;
    end
  end
  assign in_ready = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign S = s_q;
endmodule
